// File: rtl/fifo_serializer.sv
// fifo_serializer: pops words from a first-word-fall-through FIFO and shifts
// them out one bit per accepted cycle. Words stream back to back while the
// FIFO has data. The consumer may stall with shift_en=0 for any length of time.
//
// Ports
//   CLK            rising-edge clock
//   nRST           asynchronous active-low reset
//   fifo_data_out  FIFO head word (valid while fifo_empty=0)
//   fifo_empty     FIFO holds no words
//   fifo_rd_en     pops the FIFO head at the next CLK edge
//   shift_en       consumer accepts serial_out this cycle
//   flush          synchronous abort, discards any partial word
//   serial_out     current bit presented to the consumer
//   serial_valid   serial_out holds a real data bit
//   word_done      one-cycle pulse after the last bit of a word is accepted
//   busy           FSM is not IDLE
//
// state | meaning
// IDLE  | no word loaded; pops the FIFO as soon as it is non-empty
// SHIFT | word loaded; presenting bit bit_cnt, advancing on shift_en

module fifo_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic [WIDTH-1:0] fifo_data_out,
  input  logic             fifo_empty,
  output logic             fifo_rd_en,
  input  logic             shift_en,
  input  logic             flush,
  output logic             serial_out,
  output logic             serial_valid,
  output logic             word_done,
  output logic             busy
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] shreg, shreg_nxt;
  logic [CNT_W-1:0] bit_cnt, bit_cnt_nxt;
  logic             word_done_nxt;
  logic             last_bit;

  assign last_bit = (bit_cnt == LAST_CNT);
  assign busy     = (state != IDLE);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      shreg     <= '0;
      bit_cnt   <= '0;
      word_done <= 1'b0;
    end else begin
      shreg     <= shreg_nxt;
      bit_cnt   <= bit_cnt_nxt;
      word_done <= word_done_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    shreg_nxt     = shreg;
    bit_cnt_nxt   = bit_cnt;
    word_done_nxt = 1'b0;
    fifo_rd_en    = 1'b0;
    serial_valid  = 1'b0;
    serial_out    = 1'b0;

    if (flush) begin
      state_nxt   = IDLE;
      shreg_nxt   = '0;
      bit_cnt_nxt = '0;
    end else begin
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            fifo_rd_en  = 1'b1;
            shreg_nxt   = fifo_data_out;
            bit_cnt_nxt = '0;
            state_nxt   = SHIFT;
          end
        end
        SHIFT: begin
          if (shift_en) begin
            if (last_bit) begin
              word_done_nxt = 1'b1;
              bit_cnt_nxt   = '0;
              if (!fifo_empty) begin
                // Reload on the last-bit edge so the next word follows
                // without an idle cycle.
                fifo_rd_en = 1'b1;
                shreg_nxt  = fifo_data_out;
              end else begin
                shreg_nxt = '0;
                state_nxt = IDLE;
              end
            end else begin
              bit_cnt_nxt = bit_cnt + 1'b1;
              shreg_nxt   = MSB_FIRST ? (shreg << 1) : (shreg >> 1);
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end

    if (state == SHIFT) begin
      serial_valid = 1'b1;
      serial_out   = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];
    end

    // The state is already IDLE during reset, but the FIFO may be non-empty.
    // No pop may be requested until reset is released.
    if (!nRST) begin
      fifo_rd_en = 1'b0;
    end
  end

endmodule
